// File: rtl/phy_rx_serial_to_parallel.sv
// Per-lane serial-to-parallel deserializer: locks byte alignment on BC_COUNT COMMA bytes, then packs WIDTH-bit words.
// Latency: word emitted on the same edge that samples its last bit. IDLE_FILTER_EN drops all-COMMA words.
// Backpressure: none; the lane streams continuously and valid_out pulses every WIDTH bits once aligned.
module phy_rx_serial_to_parallel #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int unsigned NB  = WIDTH / 8;
  localparam int unsigned IW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned BCW = $clog2(BC_COUNT + 1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(NB - 1);
  localparam logic [BCW-1:0]   BC_LAST   = BCW'(BC_COUNT - 1);
  localparam logic [WIDTH-1:0] TOP_MASK  = WIDTH'(8'hFF) << (WIDTH - 8);
  localparam logic [WIDTH-1:0] IDLE_WORD = {NB{COMMA}};

  typedef enum logic [1:0] {SEARCH, ALIGNING, ALIGNED} state_t;

  state_t           state, state_nxt;
  // Only the 7 most recent bits need storing; the 8th is data_in itself.
  logic [6:0]       sr;
  logic [7:0]       byte_now;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [BCW-1:0]   bc_cnt, bc_cnt_nxt;
  logic [IW-1:0]    byte_idx, byte_idx_nxt;
  logic [WIDTH-1:0] word_buf, word_nxt;
  logic [IW+2:0]    slot_sh;
  logic             boundary;
  logic             word_done;
  logic             emit;

  assign byte_now = {sr, data_in};
  assign boundary = (bit_cnt == 3'd7);
  assign slot_sh  = {byte_idx, 3'b000};

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt + 3'd1;
    bc_cnt_nxt   = bc_cnt;
    byte_idx_nxt = byte_idx;
    word_nxt     = word_buf;
    word_done    = 1'b0;
    case (state)
      SEARCH: begin
        bit_cnt_nxt = '0;
        if (byte_now == COMMA) begin
          bc_cnt_nxt   = BCW'(1);
          byte_idx_nxt = '0;
          state_nxt    = (BC_COUNT == 1) ? ALIGNED : ALIGNING;
        end
      end
      ALIGNING: begin
        if (boundary) begin
          if (byte_now == COMMA) begin
            bc_cnt_nxt = bc_cnt + BCW'(1);
            if (bc_cnt == BC_LAST) begin
              state_nxt    = ALIGNED;
              byte_idx_nxt = '0;
            end
          end else begin
            state_nxt  = SEARCH;
            bc_cnt_nxt = '0;
          end
        end
      end
      ALIGNED: begin
        if (boundary) begin
          // Slot 0 sits in the top byte, so earlier bytes land in higher bits.
          word_nxt = (word_buf & ~(TOP_MASK >> slot_sh)) |
                     ((WIDTH'(byte_now) << (WIDTH - 8)) >> slot_sh);
          if (byte_idx == IDX_LAST) begin
            byte_idx_nxt = '0;
            word_done    = 1'b1;
          end else begin
            byte_idx_nxt = byte_idx + IW'(1);
          end
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

`ifdef IDLE_FILTER_EN
  assign emit = word_done && (word_nxt != IDLE_WORD);
`else
  assign emit = word_done;
`endif

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= byte_now[6:0];
      bit_cnt   <= bit_cnt_nxt;
      bc_cnt    <= bc_cnt_nxt;
      byte_idx  <= byte_idx_nxt;
      word_buf  <= word_nxt;
      valid_out <= emit;
      active    <= (state_nxt == ALIGNED);
      if (emit) begin
        data_out <= word_nxt;
      end
    end
  end

endmodule
